encrypt_out_packer: RTL
=======================

// Module: encrypt_out_packer
// PURPOSE
//  Downstream stage of the encryption unit. Collects its ciphertext bytes (dout/v) into 32-bit words,
//  little-endian, and buffers them in a small FIFO. Words are presented on a valid/ready interface
//  to the system bus. The encryption unit has no backpressure, so overflow is flagged, never stalled.
//  A flush input emits a partial word with a byte-keep mask at end of message.
// PARAMETERS
//  FIFO_DEPTH   4   word entries in output FIFO; power of 2, >=2
// PORTS
//  clk        in   1   system clock; all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  din        in   8   ciphertext byte from encryption unit dout
//  din_v      in   1   byte valid, driven by encryption unit v; one byte per cycle max
//  flush      in   1   single-cycle pulse: emit current partial word
//  dout       out  32  packed word at FIFO head; byte0 in [7:0]
//  dout_keep  out  4   byte-valid mask for dout; bit i covers dout[8i+7:8i]
//  dout_v     out  1   FIFO non-empty; dout/dout_keep valid
//  dout_rdy   in   1   consumer accepts word when dout_v & dout_rdy
//  full       out  1   FIFO holds FIFO_DEPTH words
//  overflow   out  1   sticky: a word was dropped because FIFO was full
//  level      out  $clog2(FIFO_DEPTH)+1  words currently stored
// BEHAVIOUR
//  Reset (rst=0, async): byte count=0, accumulator=0, FIFO empty, dout=0, dout_keep=0,
//   dout_v=0, full=0, overflow=0, level=0. Any partial word is discarded.
//  Assembler FSM: count 0..3 = bytes held. On din_v, the byte goes to lane [count].
//   - count==3 & din_v: push {din,acc[23:0]} with keep=4'hF; count->0 on the same edge.
//   - flush & (count+din_v)==4: same as a full push, no extra partial word.
//   - flush & 0<(count+din_v)<4: push the partial word. Unused lanes are 0.
//     keep = (1<<(count+din_v))-1. Count->0.
//   - flush with count==0 & !din_v: no-op.
//  FIFO: first-word-fall-through. dout/dout_keep reflect the head combinationally from storage.
//   dout_v = (level!=0). Pop when dout_v & dout_rdy.
//   Latency: push at edge N -> dout_v=1 and head data visible after edge N (next cycle).
//   Push and pop on the same edge: both take effect, level unchanged. This is legal when full,
//   because the pop frees a slot first.
//   Push when full and no pop: word dropped, overflow<=1 (cleared only by reset).
//   FIFO and count otherwise unchanged.
//   dout/dout_keep hold their value while dout_v & !dout_rdy. Order is strictly FIFO.
//   Pointers wrap modulo FIFO_DEPTH. full = (level==FIFO_DEPTH).
//  When empty, dout/dout_keep are don't-care. The bench checks them only when dout_v=1.
// TESTING
//  1 Bytes 11,22,33,44 on 4 consecutive cycles, rdy=1
//    -> one cycle after 4th byte: dout=32'h44332211, keep=F, dout_v high 1 cycle.
//  2 Bytes AA,BB then flush pulse
//    -> dout=32'h0000BBAA, keep=3. Then flush with byte CC on the same cycle -> dout=32'h000000CC, keep=1.
//  3 rdy=0, 20 bytes 00..13
//    -> level=4, full=1, 5th word dropped, overflow=1.
//    Then rdy=1 -> words 03020100,07060504,0B0A0908,0F0E0D0C in order, then dout_v=0.
//  4 FIFO full, rdy=1, 4th byte of new word arriving
//    -> simultaneous push/pop, level stays 4, overflow stays 0, new word last out.
//  5 Bytes with gaps (din_v 1,0,0,1,1,0,1)
//    -> a single word, keep=F, emitted after the 4th valid byte only.
//  6 Reset asserted after 2 bytes and with 2 words queued
//    -> all outputs 0 immediately. After release, 4 new bytes produce exactly one word with no stale lanes.

Source files
------------

// File: rtl/encrypt_out_packer_if.sv
// encrypt_out_packer_if: byte-in / word-out bus of the ciphertext packer.
interface encrypt_out_packer_if #(parameter int FIFO_DEPTH = 4);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic [7:0]    din;
    logic          din_v;
    logic          flush;
    logic [31:0]   dout;
    logic [3:0]    dout_keep;
    logic          dout_v;
    logic          dout_rdy;
    logic          full;
    logic          overflow;
    logic [LW-1:0] level;
    modport master (output din, din_v, flush, dout_rdy,
                    input  dout, dout_keep, dout_v, full, overflow, level);
    modport slave  (input  din, din_v, flush, dout_rdy,
                    output dout, dout_keep, dout_v, full, overflow, level);
endinterface

// File: rtl/encrypt_out_packer.sv
// encrypt_out_packer: packs ciphertext bytes into little-endian 32-bit words and queues them in a FWFT FIFO.
module encrypt_out_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    encrypt_out_packer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [1:0]    cnt_q, cnt_d;
    logic [23:0]   acc_q, acc_d;
    logic [2:0]    tot;
    logic [31:0]   word;
    logic [3:0]    keep;
    logic          push;
    logic [35:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [LW-1:0] lvl_q;
    logic          ovf_q;
    logic          full, pop, wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            acc_q <= 24'h0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    // Lanes above the byte count stay zero, so a flushed partial word needs no masking.
    always_comb begin
        tot  = {1'b0, cnt_q} + {2'b00, bus.din_v};
        word = {8'h00, acc_q};
        if (bus.din_v) word[{cnt_q, 3'b000} +: 8] = bus.din;
        cnt_d = push ? 2'd0 : tot[1:0];
        acc_d = push ? 24'h0 : word[23:0];
    end

    always_comb begin
        push = tot[2] | (bus.flush & (tot != 3'd0));
        keep = 4'((5'd1 << tot) - 5'd1);
    end

    assign full = (lvl_q == LW'(FIFO_DEPTH));
    assign pop  = (lvl_q != '0) & bus.dout_rdy;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr   = push & (!full | pop);

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= {keep, word};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_q + AW'(wr);
            rp_q  <= rp_q + AW'(pop);
            lvl_q <= lvl_q + LW'(wr) - LW'(pop);
            ovf_q <= ovf_q | (push & !wr);
        end
    end

    assign bus.dout_v                  = (lvl_q != '0);
    assign {bus.dout_keep, bus.dout}   = bus.dout_v ? mem_q[rp_q] : 36'h0;
    assign bus.full                    = full;
    assign bus.overflow                = ovf_q;
    assign bus.level                   = lvl_q;
endmodule
